// File: rtl/sine_dds.sv
// sine_dds: pipelined DDS sine oscillator (phase accumulator, quarter-wave ROM, quadrant fold).
// Define SINE_DDS_AMP_SCALE_EN to add an amplitude-scaling output stage; ROM is built at elaboration.
module sine_dds #(
   parameter int ACC_W      = 24,
   parameter int LUT_ADDR_W = 6,
   parameter int OUT_W      = 16,
   parameter int AMP_W      = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sample_tick,
   input  logic [ACC_W-1:0] phase_inc,
   input  logic             phase_sync,
   input  logic [ACC_W-1:0] phase_offset,
   input  logic [AMP_W-1:0] amplitude,
   output logic [OUT_W-1:0] sine_out,
   output logic             sample_valid,
   output logic             wrap
);
   localparam int DEPTH = 2 ** LUT_ADDR_W;
   localparam int IDX_W = LUT_ADDR_W + 2;
   localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic signed [127:0] PI_Q60 = 128'sh3243F6A8885A308D;

   // Q60 Taylor series evaluated at elaboration, rounded as round(mid + (mid-1)*sin(theta))
   function automatic logic [DEPTH*OUT_W-1:0] gen_rom();
      logic signed [127:0] th, th2, term, sum;
      logic [DEPTH*OUT_W-1:0] r;
      r = '0;
      for (int k = 0; k < DEPTH; k++) begin
         th = (PI_Q60 * 128'(2 * k + 1)) >>> IDX_W;
         th2 = (th * th) >>> 60;
         term = th;
         sum = th;
         for (int n = 1; n < 16; n++) begin
            term = -((term * th2) >>> 60) / 128'(2 * n * (2 * n + 1));
            sum = sum + term;
         end
         r[k*OUT_W +: OUT_W] = OUT_W'(((128'sd1 <<< (OUT_W + 59)) + sum * ((128'sd1 <<< (OUT_W - 1)) - 128'sd1) + (128'sd1 <<< 59)) >>> 60);
      end
      return r;
   endfunction

   localparam logic [DEPTH*OUT_W-1:0] ROM = gen_rom();

   logic [ACC_W-1:0] acc_q, acc_d, p_d;
   logic [ACC_W:0] sum;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [LUT_ADDR_W-1:0] addr;
   logic [OUT_W-1:0] raw_q, raw_d;
   logic v0_q, w0_q, w0_d, v1_q, w1_q;

   always_comb begin
      p_d = phase_sync ? phase_offset : acc_q;
      sum = {1'b0, p_d} + {1'b0, phase_inc};
      acc_d = sample_tick ? sum[ACC_W-1:0] : p_d;
      w0_d = sample_tick & ~phase_sync & sum[ACC_W];
      idx_d = p_d[ACC_W-1 -: IDX_W];
      addr = idx_q[LUT_ADDR_W] ? ~idx_q[LUT_ADDR_W-1:0] : idx_q[LUT_ADDR_W-1:0];
      raw_d = v0_q ? ROM[int'(addr)*OUT_W +: OUT_W] ^ {OUT_W{idx_q[IDX_W-1]}} : raw_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q <= '0;
         idx_q <= '0;
         v0_q  <= 1'b0;
         w0_q  <= 1'b0;
         raw_q <= MID;
         v1_q  <= 1'b0;
         w1_q  <= 1'b0;
      end else begin
         acc_q <= acc_d;
         idx_q <= idx_d;
         v0_q  <= sample_tick;
         w0_q  <= w0_d;
         raw_q <= raw_d;
         v1_q  <= v0_q;
         w1_q  <= w0_q;
      end
   end

`ifdef SINE_DDS_AMP_SCALE_EN
   localparam int PW = OUT_W + AMP_W + 1;
   logic signed [PW-1:0] s_ext, a_ext, prod;
   logic [OUT_W-1:0] y, out_q, out_d;
   logic v2_q, w2_q;

   // offset binary -> two's complement by MSB inversion, scale, and back
   always_comb begin
      s_ext = {{(AMP_W+1){~raw_q[OUT_W-1]}}, ~raw_q[OUT_W-1], raw_q[OUT_W-2:0]};
      a_ext = {{(OUT_W+1){1'b0}}, amplitude};
      prod = s_ext * a_ext;
      y = OUT_W'(prod >>> AMP_W);
      out_d = v1_q ? {~y[OUT_W-1], y[OUT_W-2:0]} : out_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_q <= MID;
         v2_q  <= 1'b0;
         w2_q  <= 1'b0;
      end else begin
         out_q <= out_d;
         v2_q  <= v1_q;
         w2_q  <= w1_q;
      end
   end

   assign sine_out     = out_q;
   assign sample_valid = v2_q;
   assign wrap         = w2_q;
`else
   logic unused_amp;
   assign unused_amp   = ^amplitude;
   assign sine_out     = raw_q;
   assign sample_valid = v1_q;
   assign wrap         = w1_q;
`endif
endmodule

// File: tb/tb_sine_dds.sv
// tb_sine_dds: scoreboard bench for sine_dds; expected samples come from a $sin-based reference.
// Build with SINE_DDS_AMP_SCALE_EN defined to cover the amplitude stage.
module tb_sine_dds;
`ifdef SINE_DDS_AMP_SCALE_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif
   localparam real PI = 3.14159265358979323846;

   typedef struct {
      logic [15:0] s;
      logic        w;
      int          due;
   } exp_t;

   logic clock, reset, sample_tick, phase_sync, sample_valid, wrap;
   logic [23:0] phase_inc, phase_offset;
   logic [7:0] amplitude;
   logic [15:0] sine_out;
   exp_t sb[$];
   logic [23:0] m_acc;
   int checks, errors, cyc;

   sine_dds dut (
      .clock(clock),
      .reset(reset),
      .sample_tick(sample_tick),
      .phase_inc(phase_inc),
      .phase_sync(phase_sync),
      .phase_offset(phase_offset),
      .amplitude(amplitude),
      .sine_out(sine_out),
      .sample_valid(sample_valid),
      .wrap(wrap)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   initial cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [15:0] rom(int k);
      return 16'(int'(32768.0 + 32767.0 * $sin((k + 0.5) * PI / 128.0)));
   endfunction

   function automatic logic [15:0] model(logic [23:0] p);
      logic [7:0] i;
      logic [15:0] v;
      i = p[23:16];
      v = i[6] ? rom(63 - int'(i[5:0])) : rom(int'(i[5:0]));
      return i[7] ? ~v : v;
   endfunction

   function automatic logic [15:0] scale(logic [15:0] r);
`ifdef SINE_DDS_AMP_SCALE_EN
      int s, y;
      s = int'(r) - 32768;
      y = (s * int'(amplitude)) >>> 8;
      return 16'(y + 32768);
`else
      return r;
`endif
   endfunction

   task automatic step(input logic tk, input logic sy, input logic [23:0] inc, input logic [23:0] off,
                       input logic lit, input logic [15:0] ls, input logic lw);
      logic [24:0] s;
      logic [23:0] base;
      exp_t e;
      sample_tick = tk;
      phase_sync = sy;
      phase_inc = inc;
      phase_offset = off;
      base = sy ? off : m_acc;
      s = {1'b0, base} + {1'b0, inc};
      if (tk) begin
         e.s = lit ? ls : scale(model(base));
         e.w = lit ? lw : (s[24] & ~sy);
         e.due = cyc + LAT;
         sb.push_back(e);
         m_acc = s[23:0];
      end else if (sy) m_acc = off;
      @(posedge clock);
      #1;
      sample_tick = 1'b0;
      phase_sync = 1'b0;
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset && sample_valid) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid: got sine_out=%h wrap=%b at cycle %0d, expected no sample", sine_out, wrap, cyc);
            end else begin
               e = sb.pop_front();
               if (sine_out !== e.s || wrap !== e.w || cyc !== e.due) begin
                  errors++;
                  $display("FAIL sample: got %h wrap=%b cycle %0d, expected %h wrap=%b cycle %0d", sine_out, wrap, cyc, e.s, e.w, e.due);
               end
            end
         end else if (!reset && sb.size() != 0 && sb[0].due <= cyc) begin
            checks++;
            errors++;
            e = sb.pop_front();
            $display("FAIL missing_valid: no sample by cycle %0d, expected %h wrap=%b at cycle %0d", cyc, e.s, e.w, e.due);
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(posedge clock);
         #1;
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d samples outstanding, expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      sample_tick = 1'b1;
      phase_inc = 24'h123456;
      for (int i = 0; i < 2; i++) begin
         @(posedge clock);
         #1;
         checks += 3;
         if (sine_out !== 16'h8000) begin errors++; $display("FAIL reset_sine: got %h, expected 8000", sine_out); end
         if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", sample_valid); end
         if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b, expected 0", wrap); end
      end
      reset = 1'b0;
      sample_tick = 1'b0;
      m_acc = '0;
      repeat (4) @(posedge clock);
      #1;
      checks++;
      if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_ticks: got valid=%b, expected 0", sample_valid); end
   endtask

   task automatic test_sweep();
      logic lit;
      logic [15:0] ls;
      step(1'b0, 1'b1, 24'h010000, 24'h000000, 1'b0, 16'h0, 1'b0);
      for (int i = 0; i < 193; i++) begin
         lit = (i == 0 || i == 1 || i == 64 || i == 128 || i == 192);
         ls = i == 0 ? 16'h8192 : i == 1 ? 16'h84B6 : i == 64 ? 16'hFFFD : i == 128 ? 16'h7E6D : 16'h0002;
         step(1'b1, 1'b0, 24'h010000, 24'h0, lit, scale(ls), 1'b0);
      end
      drain();
   endtask

   task automatic test_wrap();
      step(1'b0, 1'b1, 24'h000200, 24'hFFFF00, 1'b0, 16'h0, 1'b0);
      step(1'b1, 1'b0, 24'h000200, 24'h0, 1'b1, scale(16'h7E6D), 1'b1);
      step(1'b1, 1'b0, 24'h000200, 24'h0, 1'b1, scale(16'h8192), 1'b0);
      drain();
   endtask

   task automatic test_sync_tick();
      step(1'b1, 1'b1, 24'h000800, 24'h400000, 1'b1, scale(16'hFFFD), 1'b0);
      step(1'b1, 1'b0, 24'h000800, 24'h0, 1'b1, scale(16'hFFFD), 1'b0);
      step(1'b1, 1'b0, 24'h3F0000, 24'h0, 1'b0, 16'h0, 1'b0);
      drain();
   endtask

   task automatic test_reset_flush();
      phase_inc = 24'h250000;
      sample_tick = 1'b1;
      @(posedge clock);
      #1;
      sample_tick = 1'b0;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      m_acc = '0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         checks += 2;
         if (sample_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b, expected 0", sample_valid); end
         if (sine_out !== 16'h8000) begin errors++; $display("FAIL flush_sine: got %h, expected 8000", sine_out); end
      end
      @(posedge clock);
      #1;
      step(1'b1, 1'b0, 24'h010000, 24'h0, 1'b1, scale(16'h8192), 1'b0);
      drain();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0, 24'($urandom), 24'($urandom), 1'b0, 16'h0, 1'b0);
      drain();
   endtask

   task automatic test_amp();
`ifdef SINE_DDS_AMP_SCALE_EN
      amplitude = 8'd128;
      step(1'b1, 1'b1, 24'h0, 24'h400000, 1'b1, 16'hBFFE, 1'b0);
      drain();
      amplitude = 8'd0;
      step(1'b1, 1'b1, 24'h0, 24'h400000, 1'b1, 16'h8000, 1'b0);
      drain();
`else
      amplitude = 8'd0;
      step(1'b1, 1'b1, 24'h0, 24'h400000, 1'b1, 16'hFFFD, 1'b0);
      drain();
`endif
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_acc = '0;
      reset = 1'b1;
      sample_tick = 1'b0;
      phase_sync = 1'b0;
      phase_inc = '0;
      phase_offset = '0;
`ifdef SINE_DDS_AMP_SCALE_EN
      amplitude = 8'd200;
`else
      amplitude = 8'hA5;
`endif
      fork
         monitor();
      join_none
      test_reset();
      test_sweep();
      test_wrap();
      test_sync_tick();
      test_reset_flush();
      test_back_to_back();
      test_amp();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish within 200000 time units");
      $fatal(1);
   end
endmodule
